// File: rtl/shift_reg.sv
// Parallel-in / serial-out shift register: captures a word on i_load and
// serializes it one bit per clock, back-filling the vacated end with FILL_BIT.
module shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FILL_BIT  = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_data
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_shifted;

  // Shift direction is fixed at elaboration; the exhausted word drains to FILL_BIT.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], FILL_BIT};
      assign o_data    = r_sr[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {FILL_BIT, r_sr[WIDTH-1:1]};
      assign o_data    = r_sr[0];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else begin
      r_sr <= w_shifted;
    end
  end

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg (WIDTH=4, MSB first, fill 0): a vector table
// of load/shift cycles with hand-computed serial outputs, plus reset sequences.
module tb_shift_reg;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             sout;

  int checks;
  int failures;

  typedef struct {
    logic             load;
    logic [WIDTH-1:0] data;
    logic             expOut;
    string            name;
  } vec_t;

  vec_t vecs[$];

  shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(1'b1),
    .FILL_BIT (1'b0)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_load(load),
    .i_data(data),
    .o_data(sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic expVal);
    checks++;
    if (sout !== expVal) begin
      failures++;
      $display("[TB] FAIL %s: o_data=%b expected=%b at %0t", name, sout, expVal, $time);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge act, sample 1 ns later.
  task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] d);
    @(negedge clk);
    load = ld;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic ld, input logic [WIDTH-1:0] d, input logic e, input string n);
    vec_t v;
    v.load = ld; v.data = d; v.expOut = e; v.name = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [WIDTH-1:0] xWord;
    checks   = 0;
    failures = 0;
    xWord    = 'x;
    rst      = 1'b1;
    load     = 1'b0;
    data     = '0;

    // Load held high: reloads every edge, MSB of 4'hA stays on the line.
    for (int i = 0; i < 8; i++) addVec(1'b1, 4'hA, 1'b1, $sformatf("loadHeld%0d", i));
    // Serialize 4'hA then drain to fill; shifted-in data is X and must be ignored.
    addVec(1'b1, 4'hA, 1'b1, "serA_load");
    addVec(1'b0, xWord, 1'b0, "serA_b1");
    addVec(1'b0, xWord, 1'b1, "serA_b2");
    addVec(1'b0, xWord, 1'b0, "serA_b3");
    addVec(1'b0, xWord, 1'b0, "serA_fill1");
    addVec(1'b0, xWord, 1'b0, "serA_fill2");
    // Back-to-back words 4'hC then 4'h3.
    addVec(1'b1, 4'hC, 1'b1, "b2bC_load");
    addVec(1'b0, 4'h0, 1'b1, "b2bC_b1");
    addVec(1'b0, 4'h0, 1'b0, "b2bC_b2");
    addVec(1'b0, 4'h0, 1'b0, "b2bC_b3");
    addVec(1'b1, 4'h3, 1'b0, "b2b3_load");
    addVec(1'b0, 4'h0, 1'b0, "b2b3_b1");
    addVec(1'b0, 4'h0, 1'b1, "b2b3_b2");
    addVec(1'b0, 4'h0, 1'b1, "b2b3_b3");
    // Abort 4'hF after one shift by loading 4'h0.
    addVec(1'b1, 4'hF, 1'b1, "abortF_load");
    addVec(1'b0, 4'h0, 1'b1, "abortF_b1");
    addVec(1'b1, 4'h0, 1'b0, "abort0_load");
    addVec(1'b0, 4'h0, 1'b0, "abort0_b1");
    addVec(1'b0, 4'h0, 1'b0, "abort0_b2");
    addVec(1'b0, 4'h0, 1'b0, "abort0_b3");

    // Reset state while held in reset.
    #12;
    checkOutput("resetInit", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset between edges clears the output with no clock edge.
    applyStimulus(1'b1, 4'h8);
    checkOutput("preResetLoad8", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncReset", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].load, vecs[i].data);
      checkOutput(vecs[i].name, vecs[i].expOut);
    end

    // Reset mid-word: 4'hB = 1011, after two shifts sr=1100 so o_data=1 when reset hits.
    applyStimulus(1'b1, 4'hB);
    checkOutput("midB_load", 1'b1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("midB_b1", 1'b0);
    applyStimulus(1'b0, 4'h0);
    checkOutput("midB_b2", 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midReset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'hF);
      checkOutput($sformatf("postReset%0d", i), 1'b0);
    end
    applyStimulus(1'b1, 4'h8);
    checkOutput("postResetLoad", 1'b1);
    applyStimulus(1'b0, 4'h0);
    checkOutput("postResetShift", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
